// File: rtl/operand_fetch_regfile_if.sv
// Issue, writeback and ALU-facing operand bundle for operand_fetch_regfile.
// master = instruction source / writeback driver, slave = the register-file stage.
interface operand_fetch_regfile_if #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic              issue_valid;
  logic              issue_ready;
  logic [ADDR_W-1:0] readreg1;
  logic [ADDR_W-1:0] readreg2;
  logic [2:0]        alu_sel_in;
  logic [ADDR_W-1:0] dest_in;
  logic              write_en;
  logic [ADDR_W-1:0] writereg;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] operand1;
  logic [DATA_W-1:0] operand2;
  logic [2:0]        alu_sel_out;
  logic [ADDR_W-1:0] dest_out;
  logic              out_valid;

  modport master (
    output issue_valid, readreg1, readreg2, alu_sel_in, dest_in,
           write_en, writereg, writedata,
    input  issue_ready, operand1, operand2, alu_sel_out, dest_out, out_valid
  );

  modport slave (
    input  issue_valid, readreg1, readreg2, alu_sel_in, dest_in,
           write_en, writereg, writedata,
    output issue_ready, operand1, operand2, alu_sel_out, dest_out, out_valid
  );
endinterface

// File: rtl/operand_fetch_regfile.sv
// Register file + operand issue stage with a pending-write scoreboard ahead of the ALU.
// Optional macro REGFILE_ZERO_REG_EN makes register 0 a hard-wired zero.
module operand_fetch_regfile #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  operand_fetch_regfile_if.slave  bus
);
  localparam int ADDR_W = $clog2(NUM_REGS);

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;

  logic              wr_active;
  logic              hit1, hit2, hitd;
  logic              block1, block2, blockd;
  logic              accept;
  logic              set_pending;
  logic [DATA_W-1:0] rd_data1, rd_data2;

  // Writes aimed at a hard-wired zero register never reach the array or the scoreboard.
  assign wr_active = bus.write_en && !(ZERO_REG && (bus.writereg == '0));

  assign hit1 = wr_active && (bus.writereg == bus.readreg1);
  assign hit2 = wr_active && (bus.writereg == bus.readreg2);
  assign hitd = wr_active && (bus.writereg == bus.dest_in);

  assign block1 = pending[bus.readreg1] && !hit1;
  assign block2 = pending[bus.readreg2] && !hit2;
  assign blockd = pending[bus.dest_in]  && !hitd;

  // Ready depends only on scoreboard and writeback, never on issue_valid.
  assign bus.issue_ready = !(block1 || block2 || blockd);
  assign accept          = bus.issue_valid && bus.issue_ready;
  assign set_pending     = accept && !(ZERO_REG && (bus.dest_in == '0));

  always_comb begin
    rd_data1 = hit1 ? bus.writedata : regs[bus.readreg1];
    rd_data2 = hit2 ? bus.writedata : regs[bus.readreg2];
    if (ZERO_REG && (bus.readreg1 == '0)) rd_data1 = '0;
    if (ZERO_REG && (bus.readreg2 == '0)) rd_data2 = '0;
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    pending_nxt = pending;
    if (wr_active)   pending_nxt[bus.writereg] = 1'b0;
    // Set is applied after clear so a same-cycle set/clear leaves the bit set.
    if (set_pending) pending_nxt[bus.dest_in]  = 1'b1;
  end

  // NOTE: the register array is reset explicitly because architected state must read 0 after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      pending         <= '0;
      bus.operand1    <= '0;
      bus.operand2    <= '0;
      bus.alu_sel_out <= '0;
      bus.dest_out    <= '0;
      bus.out_valid   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all updates see pre-edge values.
      if (wr_active) regs[bus.writereg] <= bus.writedata;
      pending       <= pending_nxt;
      bus.out_valid <= accept;
      if (accept) begin
        bus.operand1    <= rd_data1;
        bus.operand2    <= rd_data2;
        bus.alu_sel_out <= bus.alu_sel_in;
        bus.dest_out    <= bus.dest_in;
      end
    end
  end

  a_issue_latency: assert property (@(posedge clk) disable iff (reset)
    accept |=> bus.out_valid);
  a_no_accept_no_valid: assert property (@(posedge clk) disable iff (reset)
    !accept |=> !bus.out_valid);

endmodule

// File: doc/operand_fetch_regfile.md
Name: operand_fetch_regfile

Overview:
- Register-file and operand-issue stage directly upstream of the 8-bit ALU (Forward/Add/And/Or, 3-bit select).
- Holds eight 8-bit general registers and reads two source operands per issued instruction.
- Presents the operands, ALU select and destination to the ALU one cycle later.
- Accepts ALU results back through a writeback port and tracks in-flight destinations with a pending-write scoreboard, stalling issue on RAW/WAW hazards.

Parameters:
- DATA_W, 8, register and operand width; must match the ALU's A/B/ALU_Out width.
- NUM_REGS, 8, number of registers; address width is log2(NUM_REGS) = 3.

Ports:
- CLK  in  1  single clock; all state changes on rising edge.
- RESET  in  1  synchronous, active-high reset.
- ISSUE_VALID  in  1  an instruction is presented this cycle.
- ISSUE_READY  out  1  combinational; stage can accept this cycle.
- READREG1  in  3  source register for operand 1 (ALU A).
- READREG2  in  3  source register for operand 2 (ALU B).
- ALU_SEL_IN  in  3  ALU operation select, carried to output.
- DEST_IN  in  3  destination register of the issued instruction.
- WRITE_EN  in  1  writeback strobe.
- WRITEREG  in  3  writeback register address.
- WRITEDATA  in  8  writeback data (ALU_Out, or external load).
- OPERAND1  out  8  registered operand to ALU A.
- OPERAND2  out  8  registered operand to ALU B.
- ALU_SEL_OUT  out  3  registered select to ALU.
- DEST_OUT  out  3  registered destination, travels with the result.
- OUT_VALID  out  1  registered; outputs hold a valid issued instruction.

Behaviour:
- Clock and reset: one clock (CLK); synchronous active-high reset (RESET).
- Reset values:
  - All eight registers = 0.
  - OPERAND1/2 = 0; ALU_SEL_OUT = 0; DEST_OUT = 0; OUT_VALID = 0.
  - All pending bits = 0.
  - Reset mid-operation discards in-flight instructions and pending state.
- Accept: ISSUE_VALID && ISSUE_READY.
- Issue latency: 1 cycle. On accept, OPERAND1/2, ALU_SEL_OUT and DEST_OUT load at the edge, and OUT_VALID = 1 the following cycle.
- No accept: OUT_VALID <= 0 and the data outputs hold their last value. The ALU has no backpressure; OUT_VALID is a per-instruction pulse.
- Write: on WRITE_EN, reg[WRITEREG] <= WRITEDATA at the edge. Writes are permitted whether or not the register is pending (covers initial loads).
- Read bypass: if WRITE_EN && WRITEREG == READREGx in the accepting cycle, OPERANDx takes WRITEDATA, not the stale register. This applies independently per port and also when READREG1 == READREG2.
- Scoreboard: one pending bit per register.
  - Set on accept for DEST_IN.
  - Cleared on WRITE_EN for WRITEREG.
  - Same register set and cleared in one cycle: set wins, and the bit stays 1.
- Hazard rule (ISSUE_READY = 0 if any of the following):
  - pending[READREG1] and not being written this cycle;
  - pending[READREG2] and not being written this cycle;
  - pending[DEST_IN] and not being written this cycle (WAW).
- ISSUE_READY is independent of ISSUE_VALID (no combinational loop). It is 1 during the reset cycle's outputs after reset.
- ALU_SEL values 100–111 pass through unchanged; the ALU resolves them to zero, and writeback still clears pending.
- Address range: all 3-bit addresses are legal; there is no out-of-range case.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined:
  - Register 0 reads as 0 on both ports, including via bypass.
  - Writes to register 0 are ignored.
  - pending[0] is never set.
  - DEST_IN = 0 never stalls.
- Undefined: register 0 is an ordinary register, as described above.

Test Plan:
- Reset: RESET=1 for 2 cycles → all outputs 0, ISSUE_READY=1; reading R0..R7 yields 0.
- Load and issue:
  - Stimulus: write R1=8'h0A and R2=8'h02 (no issue); then issue READREG1=1, READREG2=2, ALU_SEL_IN=001, DEST_IN=3.
  - Required: next cycle OPERAND1=0A, OPERAND2=02, ALU_SEL_OUT=001, DEST_OUT=3, OUT_VALID=1; following cycle OUT_VALID=0.
- RAW stall then bypass:
  - Stimulus: after the issue above, present READREG1=3 → ISSUE_READY=0 while R3 is pending.
  - Required: in the cycle WRITE_EN=1, WRITEREG=3, WRITEDATA=0C, ISSUE_READY=1 and OPERAND1=0C next cycle.
- WAW and set-wins:
  - Stimulus: DEST_IN=4 pending; issue another op to DEST 4 in the same cycle as writeback to R4.
  - Required: accepted, pending[4] remains 1, and a subsequent read of R4 stalls.
- Same-source bypass: READREG1=READREG2=5 with a simultaneous write R5=8'hFF → OPERAND1=OPERAND2=FF.
- Reset mid-flight: pending R6, assert RESET for 1 cycle → pending cleared, OUT_VALID=0, and an issue reading R6 is accepted immediately with operand 0.
- With REGFILE_ZERO_REG_EN: write R0=8'h55 then read R0 → 0, and DEST_IN=0 never deasserts ISSUE_READY.
